// File: rtl/multi_chan_counter_if.sv
// Snapshot handshake bundle for multi_chan_counter: the counter block is master,
// the snapshot consumer is slave.
interface multi_chan_counter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      snap_req;
  logic                      snap_valid;
  logic                      snap_ready;
  logic [CHANNELS*WIDTH-1:0] snap_data;

  // snap_valid/snap_data stay stable while snap_valid is high; a transfer
  // happens on a rising edge where snap_valid && snap_ready.
  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data
  );
endinterface

// File: rtl/multi_chan_counter.sv
// Bank of independent up/down counters with limit pulses and a coherent snapshot port.
// Optional sticky overflow flags are built when MULTI_CHAN_COUNTER_OVF_STICKY_EN is defined.
module multi_chan_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_data,
  output logic [CHANNELS*WIDTH-1:0] data,
  output logic [CHANNELS-1:0]       limit,
  multi_chan_counter_if.master      snap,
  output logic [CHANNELS-1:0]       ovf,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic                      snap_state
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] at_bound;
  logic [CHANNELS-1:0] limit_d;
  snap_state_t         state_q;
  snap_state_t         state_d;
  logic                capture;

  always_comb begin
    at_bound = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      at_bound[n] = down[n] ? (cnt_q[n] == '0) : (cnt_q[n] == MAX_VAL);
    end
  end

  // clear > load > enable > hold; only an enabled step can raise a limit event
  always_comb begin
    limit_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      cnt_d[n] = cnt_q[n];
      if (clear[n]) begin
        cnt_d[n] = '0;
      end else if (load[n]) begin
        cnt_d[n] = load_data;
      end else if (enable[n]) begin
        limit_d[n] = at_bound[n];
        if (!((SATURATE != 0) && at_bound[n])) begin
          cnt_d[n] = down[n] ? (cnt_q[n] - ONE) : (cnt_q[n] + ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        cnt_q[n] <= '0;
      end
      limit <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
      limit <= limit_d;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_pack
    assign data[n*WIDTH +: WIDTH] = cnt_q[n];
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap.snap_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (snap.snap_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture takes the registered (pre-update) counts of the request edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      snap.snap_data <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        snap.snap_data <= data;
      end
    end
  end

  assign snap.snap_valid = (state_q == HOLD);
  assign snap_state      = (state_q == HOLD);

`ifdef MULTI_CHAN_COUNTER_OVF_STICKY_EN
  logic [CHANNELS-1:0] ovf_q;

  // A new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | limit_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic [CHANNELS-1:0] ovf_clr_unused;

  assign ovf_clr_unused = ovf_clr;
  assign ovf            = '0;
`endif

endmodule

// File: tb/tb_multi_chan_counter.sv
// Directed bench for multi_chan_counter: a wrapping and a saturating instance share stimulus.
module tb_multi_chan_counter;
  localparam int W = 8;
  localparam int C = 4;
`ifdef MULTI_CHAN_COUNTER_OVF_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [C-1:0] enable, down, clear, load, ovf_clr;
  logic [W-1:0] load_data;
  logic [C*W-1:0] data_w, data_s;
  logic [C-1:0] limit_w, limit_s, ovf_w, ovf_s;
  logic         state_w, state_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_chan_counter_if #(.WIDTH(W), .CHANNELS(C)) snap_w ();
  multi_chan_counter_if #(.WIDTH(W), .CHANNELS(C)) snap_s ();

  multi_chan_counter #(.WIDTH(W), .CHANNELS(C), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .down(down), .clear(clear),
    .load(load), .load_data(load_data), .data(data_w), .limit(limit_w),
    .snap(snap_w.master), .ovf(ovf_w), .ovf_clr(ovf_clr), .snap_state(state_w)
  );

  multi_chan_counter #(.WIDTH(W), .CHANNELS(C), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .down(down), .clear(clear),
    .load(load), .load_data(load_data), .data(data_s), .limit(limit_s),
    .snap(snap_s.master), .ovf(ovf_s), .ovf_clr(ovf_clr), .snap_state(state_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ch(input logic [C*W-1:0] d, input int n);
    return d[n*W +: W];
  endfunction

  initial begin
    int          pulses;
    logic [W-1:0] exp_sat_cnt [5];
    logic        exp_sat_lim [5];
    logic [W-1:0] vals [4];

    exp_sat_cnt = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_sat_lim = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vals        = '{8'd3, 8'd7, 8'd9, 8'd11};

    rst = 1'b1;
    enable = '0; down = '0; clear = '0; load = '0; ovf_clr = '0; load_data = '0;
    snap_w.snap_req = 1'b0; snap_w.snap_ready = 1'b0;
    snap_s.snap_req = 1'b0; snap_s.snap_ready = 1'b0;

    #12;
    check("rst_data", data_w, 0);
    check("rst_limit", limit_w, 0);
    check("rst_snap_valid", snap_w.snap_valid, 0);
    check("rst_snap_data", snap_w.snap_data, 0);
    check("rst_ovf", ovf_w, 0);
    check("rst_state", state_w, 0);
    step();
    rst = 1'b0;

    // Channel 0 counts up through the wrap
    enable = 4'b0001;
    pulses = 0;
    for (int i = 1; i <= 257; i++) begin
      step();
      if (limit_w[0]) pulses++;
      if (i == 255) begin
        check("wrap_cnt_255", ch(data_w, 0), 8'd255);
        check("wrap_lim_255", limit_w[0], 0);
      end
      if (i == 256) begin
        check("wrap_cnt_256", ch(data_w, 0), 8'd0);
        check("wrap_lim_256", limit_w[0], 1);
      end
      if (i == 257) begin
        check("wrap_cnt_257", ch(data_w, 0), 8'd1);
        check("wrap_lim_257", limit_w[0], 0);
      end
    end
    enable = '0;
    check("wrap_pulses", pulses, 1);
    check("sat_ch0_max", ch(data_s, 0), 8'd255);
    check("wrap_ovf0", ovf_w, {3'b000, STICKY});

    // Channel 1 decrements from 2
    load = 4'b0010; load_data = 8'h02;
    step();
    load = '0;
    check("sat_load", ch(data_s, 1), 8'h02);
    enable = 4'b0010; down = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("sat_dn_cnt%0d", k), ch(data_s, 1), exp_sat_cnt[k]);
      check($sformatf("sat_dn_lim%0d", k), limit_s[1], exp_sat_lim[k]);
    end
    enable = '0; down = '0;
    step();
    check("sat_lim_off", limit_s[1], 0);
    check("wrap_dn_cnt", ch(data_w, 1), 8'd253);

    // Channel 2 priority: clear beats load and enable, and both suppress limit
    load = 4'b0100; load_data = 8'h10;
    step();
    clear = 4'b0100; load = 4'b0100; enable = 4'b0100; load_data = 8'h55;
    step();
    clear = '0; load = '0; enable = '0;
    check("prio_clr_cnt", ch(data_w, 2), 8'h00);
    check("prio_clr_lim", limit_w[2], 0);
    load = 4'b0100; load_data = 8'hFF;
    step();
    enable = 4'b0100; load_data = 8'h20;
    step();
    load = '0; enable = '0;
    check("prio_ld_cnt", ch(data_w, 2), 8'h20);
    check("prio_ld_lim", limit_w[2], 0);

    // Snapshot of {3,7,9,11} while all channels keep counting
    for (int i = 0; i < 4; i++) begin
      load = 4'(1 << i); load_data = vals[i];
      step();
    end
    load = '0;
    snap_w.snap_req = 1'b1; enable = 4'b1111;
    step();
    snap_w.snap_req = 1'b0;
    check("snap_valid", snap_w.snap_valid, 1);
    check("snap_data", snap_w.snap_data, 32'h0B09_0703);
    check("snap_live", data_w, 32'h0C0A_0804);
    check("snap_state", state_w, 1);
    for (int k = 0; k < 5; k++) begin
      snap_w.snap_req = (k == 2);
      step();
      check($sformatf("hold_valid%0d", k), snap_w.snap_valid, 1);
      check($sformatf("hold_data%0d", k), snap_w.snap_data, 32'h0B09_0703);
    end
    snap_w.snap_ready = 1'b1; snap_w.snap_req = 1'b1;
    step();
    snap_w.snap_ready = 1'b0; snap_w.snap_req = 1'b0;
    check("done_valid", snap_w.snap_valid, 0);
    check("done_state", state_w, 0);
    step();
    check("done_req_ignored", snap_w.snap_valid, 0);
    enable = '0;

    // Asynchronous reset in the middle of HOLD
    snap_w.snap_req = 1'b1;
    step();
    snap_w.snap_req = 1'b0;
    check("hold_before_rst", snap_w.snap_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", snap_w.snap_valid, 0);
    check("arst_data", data_w, 0);
    check("arst_snap_data", snap_w.snap_data, 0);
    check("arst_limit", limit_w, 0);
    check("arst_ovf", ovf_w, 0);
    #2 rst = 1'b0;
    step();
    load = 4'b0001; load_data = 8'h05;
    step();
    load = '0;
    snap_w.snap_req = 1'b1;
    step();
    snap_w.snap_req = 1'b0;
    check("post_rst_valid", snap_w.snap_valid, 1);
    check("post_rst_data", snap_w.snap_data, 32'h0000_0005);
    snap_w.snap_ready = 1'b1;
    step();
    snap_w.snap_ready = 1'b0;
    check("post_rst_done", snap_w.snap_valid, 0);

    // Sticky flag on channel 3
    load = 4'b1000; load_data = 8'hFF;
    step();
    load = '0; enable = 4'b1000;
    step();
    enable = '0;
    check("ovf_wrap1", ovf_w, {STICKY, 3'b000});
    step(2);
    check("ovf_hold", ovf_w[3], STICKY);
    load = 4'b1000;
    step();
    load = '0; enable = 4'b1000;
    step();
    enable = '0;
    check("ovf_wrap2", ovf_w[3], STICKY);
    ovf_clr = 4'b1000;
    step();
    ovf_clr = '0;
    check("ovf_clr", ovf_w[3], 0);
    load = 4'b1000;
    step();
    load = '0; enable = 4'b1000; ovf_clr = 4'b1000;
    step();
    enable = '0; ovf_clr = '0;
    check("ovf_set_prio_lim", limit_w[3], 1);
    check("ovf_set_prio", ovf_w[3], STICKY);
    ovf_clr = 4'b1000;
    step();
    ovf_clr = '0;
    check("ovf_clr2", ovf_w[3], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
